// File: rtl/fetch_execute_controller_pkg.sv
// Shared definitions for the 16-bit accumulator machine.
//   - Instruction opcodes (ir[15:12]) OP_NOP .. OP_HALT
//   - ALU operation selects, shared with the ALU block
//   - Sequencer state enum
//   - Helpers that map an instruction opcode to its ALU op and
//     report whether it reads a memory operand
package fetch_execute_controller_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_JUMP  = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_JN    = 4'hC;
    localparam logic [3:0] OP_LOADI = 4'hD;
    localparam logic [3:0] OP_CMPEQ = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SHL = 4'b0100;
    localparam logic [3:0] ALU_SHR = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;
    localparam logic [3:0] ALU_EQ  = 4'b1111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        LATCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_e;

    // Ops that do not use the ALU select ADD (0000), which is harmless
    // because their result is never captured.
    function automatic logic [3:0] alu_op_for(input logic [3:0] op);
        case (op)
            OP_SUB:   return ALU_SUB;
            OP_AND:   return ALU_AND;
            OP_OR:    return ALU_OR;
            OP_XOR:   return ALU_XOR;
            OP_SHL:   return ALU_SHL;
            OP_SHR:   return ALU_SHR;
            OP_CMPEQ: return ALU_EQ;
            default:  return ALU_ADD;
        endcase
    endfunction

    function automatic logic has_mem_operand(input logic [3:0] op);
        case (op)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMPEQ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_execute_controller.sv
// Multi-cycle fetch/latch/decode/execute sequencer for the accumulator
// machine. Owns PC, IR and AC; drives a synchronous memory (one-cycle
// read latency) and a combinational ALU that live alongside it.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   mem_rdata               memory read data, valid cycle after address
//   mem_addr/wdata/we       memory address, write data (=AC), write enable
//   alu_opcode/a/b          ALU select, operand1 (=AC), operand2 (=mem_rdata)
//   alu_result              ALU combinational result
//   pc, ir, ac              architectural registers
//   halted                  high once HALT has executed
module fetch_execute_controller
    import fetch_execute_controller_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] ac,
    output logic              halted
);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] ac_q;
    logic              halted_q;
    logic              mem_we_q;

    logic [3:0]        opcode;
    logic [11:0]       operand;
    logic [ADDR_W-1:0] operand_addr;

    assign opcode       = ir_q[DATA_W-1 -: 4];
    assign operand      = ir_q[11:0];
    assign operand_addr = ADDR_W'(operand);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            ac_q     <= '0;
            halted_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: state_q <= LATCH;
                LATCH: begin
                    ir_q     <= mem_rdata;
                    pc_q     <= pc_q + ADDR_W'(1);
                    // Write enable is registered one state early so it is
                    // a clean flop output for exactly the DECODE cycle.
                    mem_we_q <= (mem_rdata[DATA_W-1 -: 4] == OP_STORE);
                    state_q  <= DECODE;
                end
                DECODE: begin
                    mem_we_q <= 1'b0;
                    state_q  <= FETCH;
                    case (opcode)
                        OP_SHL, OP_SHR: ac_q <= alu_result;
                        OP_JUMP:        pc_q <= operand_addr;
                        OP_JZ:          if (ac_q == '0) pc_q <= operand_addr;
                        OP_JN:          if (ac_q[DATA_W-1]) pc_q <= operand_addr;
                        OP_LOADI:       ac_q <= DATA_W'(operand);
                        OP_HALT: begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end
                        default: if (has_mem_operand(opcode)) state_q <= EXEC;
                    endcase
                end
                EXEC: begin
                    ac_q    <= (opcode == OP_LOAD) ? mem_rdata : alu_result;
                    state_q <= FETCH;
                end
                HALT:    state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

    // Operand address is held through EXEC so the read issued in DECODE
    // and any data-dependent memory view stay consistent.
    always_comb begin
        mem_addr = pc_q;
        if (state_q == DECODE || state_q == EXEC) mem_addr = operand_addr;
    end

    assign mem_wdata  = ac_q;
    assign mem_we     = mem_we_q;
    assign alu_opcode = alu_op_for(opcode);
    assign alu_a      = ac_q;
    assign alu_b      = mem_rdata;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign ac         = ac_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_execute_controller.sv
module tb_fetch_execute_controller;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 16;
    localparam int MEM_WORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [3:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir, ac;
    logic              halted;

    always #5 clk = ~clk;

    fetch_execute_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .alu_opcode(alu_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .pc(pc), .ir(ir), .ac(ac), .halted(halted)
    );

    // Combinational ALU environment
    always_comb begin
        case (alu_opcode)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0100: alu_result = alu_a << 1;
            4'b0101: alu_result = alu_a >> 1;
            4'b1000: alu_result = alu_a & alu_b;
            4'b1001: alu_result = alu_a | alu_b;
            4'b1010: alu_result = alu_a ^ alu_b;
            4'b1111: alu_result = (alu_a == alu_b) ? 16'd1 : 16'd0;
            default: alu_result = '0;
        endcase
    end

    // Synchronous memory with a backdoor load/clear port for the bench
    logic [15:0] mem [0:MEM_WORDS-1];
    logic        clr_req = 1'b0;
    logic        ld_en = 1'b0;
    logic [13:0] ld_addr = '0;
    logic [15:0] ld_data = '0;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (clr_req) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
        end else if (ld_en) begin
            mem[ld_addr] = ld_data;
        end else if (mem_we) begin
            mem[mem_addr] = mem_wdata;
        end
    end

    // Instruction-level reference model
    logic [15:0] mref [0:MEM_WORDS-1];
    logic [13:0] mpc;
    logic [15:0] mac, mir;
    bit          mhalt;
    int          tot_we;

    int    n_chk = 0;
    int    n_pass = 0;
    string tname = "init";

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tname, tag, got, exp);
    endtask

    task automatic prog_begin(input string name);
        tname = name;
        @(negedge clk);
        reset = 1'b1;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) mref[i] = '0;
    endtask

    task automatic put(input int a, input logic [15:0] d);
        ld_addr = 14'(a);
        ld_data = d;
        ld_en   = 1'b1;
        mref[a] = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic prog_go();
        mpc = '0; mac = '0; mir = '0; mhalt = 0; tot_we = 0;
        reset = 1'b0;
    endtask

    // Executes one instruction on the model; returns its cycle count,
    // expected number of write-enable cycles and store address (or -1).
    task automatic model_step(output int lat, output int nwe, output int saddr);
        logic [15:0] ins;
        logic [13:0] x;
        ins   = mref[mpc];
        mir   = ins;
        mpc   = mpc + 14'd1;
        x     = {2'b00, ins[11:0]};
        lat   = 3;
        nwe   = 0;
        saddr = -1;
        case (ins[15:12])
            4'h1: begin mac = mref[x]; lat = 4; end
            4'h2: begin mref[x] = mac; nwe = 1; saddr = int'(x); end
            4'h3: begin mac = mac + mref[x]; lat = 4; end
            4'h4: begin mac = mac - mref[x]; lat = 4; end
            4'h5: begin mac = mac & mref[x]; lat = 4; end
            4'h6: begin mac = mac | mref[x]; lat = 4; end
            4'h7: begin mac = mac ^ mref[x]; lat = 4; end
            4'h8: mac = mac << 1;
            4'h9: mac = mac >> 1;
            4'hA: mpc = x;
            4'hB: if (mac == 16'd0) mpc = x;
            4'hC: if (mac[15]) mpc = x;
            4'hD: mac = {4'h0, ins[11:0]};
            4'hE: begin mac = (mac == mref[x]) ? 16'd1 : 16'd0; lat = 4; end
            4'hF: mhalt = 1;
            default: ;
        endcase
    endtask

    task automatic run_steps(input int n);
        int lat, nwe, saddr, seen;
        for (int k = 0; k < n && !mhalt; k++) begin
            model_step(lat, nwe, saddr);
            seen = 0;
            for (int c = 0; c < lat; c++) begin
                if (mem_we) seen++;
                @(negedge clk);
            end
            tot_we += seen;
            check_eq("pc", 32'(pc), 32'(mpc));
            check_eq("ac", 32'(ac), 32'(mac));
            check_eq("ir", 32'(ir), 32'(mir));
            check_eq("halted", 32'(halted), 32'(mhalt));
            check_eq("we_cycles", seen, nwe);
            check_eq("addr", 32'(mem_addr), 32'(mpc));
            if (saddr >= 0) check_eq("stored", 32'(mem[saddr]), 32'(mref[saddr]));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        tname = "reset";
        check_eq("pc", 32'(pc), 0);
        check_eq("ir", 32'(ir), 0);
        check_eq("ac", 32'(ac), 0);
        check_eq("halted", 32'(halted), 0);
        check_eq("mem_we", 32'(mem_we), 0);
        check_eq("addr", 32'(mem_addr), 0);

        // LOAD then HALT
        prog_begin("load_halt");
        put(0, 16'h1010); put(1, 16'hF000); put(16'h10, 16'h1234);
        prog_go();
        run_steps(1);
        check_eq("ac_c4", 32'(ac), 32'h1234);
        run_steps(1);
        check_eq("halted_c7", 32'(halted), 1);
        repeat (4) @(negedge clk);
        check_eq("pc_hold", 32'(pc), 2);
        check_eq("halt_hold", 32'(halted), 1);
        check_eq("we_hold", 32'(mem_we), 0);

        // ADD / STORE
        prog_begin("add_store");
        put(0, 16'h1010); put(1, 16'h3011); put(2, 16'h2012); put(3, 16'hF000);
        put(16'h10, 16'd5); put(16'h11, 16'd7);
        prog_go();
        run_steps(4);
        check_eq("mem12", 32'(mem[16'h12]), 12);
        check_eq("we_total", tot_we, 1);

        // Conditional jumps
        prog_begin("jz_taken");
        put(0, 16'hD000); put(1, 16'hB020);
        prog_go();
        run_steps(2);
        check_eq("pc", 32'(pc), 32'h20);
        prog_begin("jz_not");
        put(0, 16'hD001); put(1, 16'hB020);
        prog_go();
        run_steps(2);
        check_eq("pc", 32'(pc), 2);
        prog_begin("jn_taken");
        put(0, 16'h1010); put(1, 16'hC020); put(16'h10, 16'h8000);
        prog_go();
        run_steps(2);
        check_eq("pc", 32'(pc), 32'h20);

        // SUB wrap and SHL
        prog_begin("wrap_arith");
        put(0, 16'hD000); put(1, 16'h4010); put(2, 16'h1011); put(3, 16'h8000); put(4, 16'hF000);
        put(16'h10, 16'd1); put(16'h11, 16'h8001);
        prog_go();
        run_steps(2);
        check_eq("sub_wrap", 32'(ac), 32'hFFFF);
        run_steps(2);
        check_eq("shl", 32'(ac), 32'h0002);
        run_steps(1);

        // Jump to self
        prog_begin("self_loop");
        put(0, 16'hA000);
        prog_go();
        run_steps(3);
        check_eq("pc", 32'(pc), 0);

        // PC wrap through top of memory
        prog_begin("pc_wrap");
        put(0, 16'hAFFF);
        prog_go();
        run_steps(1);
        check_eq("pc_fff", 32'(pc), 32'hFFF);
        run_steps(MEM_WORDS - 32'hFFF);
        check_eq("pc_wrapped", 32'(pc), 0);

        // Reset during DECODE of STORE
        prog_begin("reset_store");
        put(0, 16'hD055); put(1, 16'h2030); put(16'h30, 16'hBEEF);
        prog_go();
        run_steps(1);
        @(negedge clk);
        @(negedge clk);
        check_eq("we_decode", 32'(mem_we), 1);
        check_eq("addr_decode", 32'(mem_addr), 32'h30);
        #2 reset = 1'b1;
        #1;
        check_eq("we_async", 32'(mem_we), 0);
        check_eq("pc", 32'(pc), 0);
        check_eq("ac", 32'(ac), 0);
        check_eq("ir", 32'(ir), 0);
        @(negedge clk);
        check_eq("target_kept", 32'(mem[16'h30]), 32'hBEEF);
        prog_go();
        check_eq("restart_addr", 32'(mem_addr), 0);
        run_steps(2);
        check_eq("store_after", 32'(mem[16'h30]), 32'h0055);

        // Random programs
        for (int p = 0; p < 8; p++) begin
            prog_begin($sformatf("rand%0d", p));
            for (int a = 0; a < 48; a++) begin
                logic [3:0]  op;
                logic [11:0] opnd;
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
                if (op == 4'hA || op == 4'hB || op == 4'hC) opnd = 12'($urandom_range(0, 47));
                else if (op == 4'hD || op == 4'h0 || op == 4'h8 || op == 4'h9 || op == 4'hF)
                    opnd = 12'($urandom_range(0, 4095));
                else opnd = 12'h100 + 12'($urandom_range(0, 15));
                put(a, {op, opnd});
            end
            for (int d = 0; d < 16; d++) begin
                logic [15:0] v;
                case ($urandom_range(0, 3))
                    0: v = 16'h0000;
                    1: v = 16'h8000 | 16'($urandom);
                    default: v = 16'($urandom);
                endcase
                put(16'h100 + d, v);
            end
            prog_go();
            run_steps(80);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_execute_controller.md
Name: fetch_execute_controller

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator machine.
- Owns the PC, IR and AC registers.
- Drives the synchronous main memory (address, write data, write enable) and the combinational ALU (opcode, operands), and consumes their outputs.
- Sits directly upstream of the ALU and main memory; a top-level wrapper instantiates all three.

Parameters:
- ADDR_W, 14, memory address width (16Ki words); PC width.
- DATA_W, 16, data, instruction and AC width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the address is presented.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data (= AC).
- mem_we  out  1  memory write enable.
- alu_opcode  out  4  ALU operation select.
- alu_a  out  DATA_W  ALU operand1 (= AC).
- alu_b  out  DATA_W  ALU operand2 (= mem_rdata).
- alu_result  in  DATA_W  ALU combinational result.
- pc  out  ADDR_W  program counter.
- ir  out  DATA_W  instruction register.
- ac  out  DATA_W  accumulator.
- halted  out  1  high once HALT has executed.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: pc=0, ir=0, ac=0, state=FETCH, halted=0, mem_we=0.
- A reset mid-instruction aborts it. No write is issued after the reset edge; execution restarts at FETCH with pc=0.
- Instruction format: opcode=ir[15:12], operand=ir[11:0], zero-extended to ADDR_W.
- States:
  - FETCH: mem_addr=pc, mem_we=0 -> LATCH.
  - LATCH: ir<=mem_rdata, pc<=pc+1 (wraps 2^ADDR_W-1 -> 0 silently) -> DECODE.
  - DECODE: mem_addr=operand. Memory-operand ops -> EXEC. STORE asserts mem_we=1, mem_wdata=ac, then -> FETCH. All other ops complete here -> FETCH.
  - EXEC: mem_rdata is valid; ac<=mem_rdata (LOAD) or ac<=alu_result (ALU ops) -> FETCH.
  - HALT: terminal; halted=1, mem_we=0; only reset exits.
- Opcodes (ALU op in brackets):
  - 0 NOP.
  - 1 LOAD X.
  - 2 STORE X.
  - 3 ADD X [0000].
  - 4 SUB X [0001].
  - 5 AND X [1000].
  - 6 OR X [1001].
  - 7 XOR X [1010].
  - 8 SHL [0100], ac<=alu_result in DECODE.
  - 9 SHR [0101], ac<=alu_result in DECODE.
  - A JUMP X: pc<=X in DECODE.
  - B JZ X: pc<=X if ac==0.
  - C JN X: pc<=X if ac[15]==1.
  - D LOADI: ac<=operand.
  - E CMPEQ X [1111], ac<=alu_result.
  - F HALT.
- Latency: memory-operand ops take 4 cycles; STORE, jumps, shifts, NOP and LOADI take 3 cycles.
- alu_opcode is driven from the decoded ir in every state; defaults to 0000 when the op does not use the ALU.
- mem_we is high only in DECODE of STORE, for exactly one cycle.
- mem_addr: pc in FETCH, operand in DECODE/EXEC, pc otherwise.
- Arithmetic wraps modulo 2^16 in the ALU; the controller adds no flags.
- A jump taken to the current pc is legal and yields a tight loop.
- Conditional jump not taken: pc is unchanged from LATCH (already incremented).

Decomposition:
- Shared package holds:
  - opcode localparams OP_NOP..OP_HALT;
  - ALU opcode constants (ALU_ADD, ALU_SUB, ALU_SHL, ALU_EQ, ...), also used by the ALU;
  - state enum (FETCH, LATCH, DECODE, EXEC, HALT).
- No sub-module: a single FSM plus datapath registers. The ALU and memory stay separate and are instantiated at top level.

Test Plan:
- LOAD then HALT: mem[0]=0x1010, mem[1]=0xF000, mem[0x10]=0x1234 -> ac=0x1234 at cycle 4; halted=1 by cycle 7; pc stays 2.
- ADD/STORE: mem[0x10]=5, mem[0x11]=7, program LOAD 10; ADD 11; STORE 12; HALT -> mem[0x12]=12; mem_we high exactly one cycle.
- Conditional jumps: LOADI 0; JZ 0x20 -> pc=0x20. LOADI 1; JZ 0x20 -> not taken, pc=next. ac=0x8000 with JN -> taken.
- Sub wrap: ac=0, SUB X with mem[X]=1 -> ac=0xFFFF; SHL on 0x8001 -> 0x0002.
- PC wrap: JUMP to 0xFFF, then step through the top of memory with NOPs -> pc wraps 0x3FFF -> 0 without error.
- Reset during DECODE of STORE -> mem_we deasserts immediately, target word unchanged, pc=ac=ir=0, next cycle is FETCH of address 0.
